// File: rtl/wb_regfile_pkg.sv
// Shared write-back definitions: Mem2Reg source encodings and default widths.
// Used by the W-stage control unit and by the register file.
package wb_regfile_pkg;

  localparam logic [1:0] WB_SRC_AO   = 2'd0;
  localparam logic [1:0] WB_SRC_DM   = 2'd1;
  localparam logic [1:0] WB_SRC_LINK = 2'd2;
  localparam logic [1:0] WB_SRC_RSV  = 2'd3;

  localparam int WB_DATA_W      = 32;
  localparam int WB_ADDR_W      = 5;
  localparam int WB_LINK_OFFSET = 8;

endpackage

// File: rtl/wb_data_mux.sv
// Write-data select for the W stage: AO, load data or PC+LINK_OFFSET (reserved code falls back to AO).
// Purely combinational, zero latency, no backpressure.
module wb_data_mux
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int LINK_OFFSET = WB_LINK_OFFSET
) (
  input  logic [1:0]        Mem2Reg,
  input  logic [DATA_W-1:0] AO_W,
  input  logic [DATA_W-1:0] DM_W,
  input  logic [DATA_W-1:0] PC_W,
  output logic [DATA_W-1:0] WD
);

  always_comb begin
    WD = AO_W;
    case (Mem2Reg)
      WB_SRC_DM:   WD = DM_W;
      WB_SRC_LINK: WD = PC_W + DATA_W'(LINK_OFFSET);
      default:     WD = AO_W;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 32xDATA_W GPR file with write-data select, combinational reads and a committed-write counter.
// Writes land one edge later; reads are same-cycle; WB_BYPASS_EN enables W->D write-through.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int ADDR_W      = WB_ADDR_W,
  parameter int LINK_OFFSET = WB_LINK_OFFSET
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWE,
  input  logic [1:0]        Mem2Reg,
  input  logic [ADDR_W-1:0] A3,
  input  logic [DATA_W-1:0] AO_W,
  input  logic [DATA_W-1:0] DM_W,
  input  logic [DATA_W-1:0] PC_W,
  input  logic [ADDR_W-1:0] A1,
  input  logic [ADDR_W-1:0] A2,
  output logic [DATA_W-1:0] RD1,
  output logic [DATA_W-1:0] RD2,
  output logic [DATA_W-1:0] WD,
  output logic [31:0]       WrCount
);

  localparam int NREG = 2 ** ADDR_W;

  logic [DATA_W-1:0] gpr_q [NREG];
  logic [DATA_W-1:0] gpr_d [NREG];
  logic [31:0]       wr_count_q;
  logic [31:0]       wr_count_d;
  logic              commit;

  wb_data_mux #(
    .DATA_W      (DATA_W),
    .LINK_OFFSET (LINK_OFFSET)
  ) u_mux (
    .Mem2Reg (Mem2Reg),
    .AO_W    (AO_W),
    .DM_W    (DM_W),
    .PC_W    (PC_W),
    .WD      (WD)
  );

  // r0 is hardwired zero, so a write to it is neither stored nor counted.
  assign commit = RegWE && (A3 != '0);

  always_comb begin
    gpr_d      = gpr_q;
    wr_count_d = wr_count_q;
    if (commit) begin
      gpr_d[A3]  = WD;
      wr_count_d = wr_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) gpr_q[i] <= '0;
      wr_count_q <= '0;
    end else begin
      gpr_q      <= gpr_d;
      wr_count_q <= wr_count_d;
    end
  end

  always_comb begin
    RD1 = (A1 == '0) ? '0 : gpr_q[A1];
    RD2 = (A2 == '0) ? '0 : gpr_q[A2];
`ifdef WB_BYPASS_EN
    if (commit && (A1 == A3)) RD1 = WD;
    if (commit && (A2 == A3)) RD2 = WD;
`endif
  end

  assign WrCount = wr_count_q;

endmodule
